me_mem_access: RTL
==================

Name: me_mem_access

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Turns the me_* load/store controls, address and store data into a request/acknowledge transaction on the data-memory bus.
- Stalls the pipeline while a transaction is outstanding, and returns aligned, sign/zero-extended load data to the writeback path.
- Sits between the EX/MEM register and the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for dmem_ack before aborting with mem_bus_err (1..255, 8-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
flush  in  1  discard result of current MEM-stage instruction
me_write_ram_flag  in  2  0 none, 1 sb, 2 sh, 3 sw
me_read_ram_flag  in  3  0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6-7 treated as none
me_alu_out  in  32  effective byte address
me_rs2_data  in  32  store source data
dmem_req  out  1  bus request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word address ({me_alu_out[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables (0000 on reads)
dmem_ack  in  1  bus completion, sampled only in REQ
dmem_rdata  in  32  read word, valid with dmem_ack
mem_stall  out  1  hold IF..EX/MEM stages this cycle
mem_load_data  out  32  extended load result
mem_load_valid  out  1  one-cycle pulse, load result ready
mem_bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- access = (me_write_ram_flag != 0) | (me_read_ram_flag in 1..5).
- Write has priority if both flags are nonzero; the read is ignored.
- States:
  - IDLE: on access (and not flush), latch all dmem_* outputs, clear the counter, go to REQ.
  - REQ: dmem_req = 1, outputs stable. On dmem_ack, capture the extended rdata and go to DONE. Otherwise increment the counter; when counter == TIMEOUT_CYCLES-1, go to DONE with mem_bus_err = 1 and load data 0.
  - DONE: one cycle, then IDLE.
- mem_stall = (IDLE & access & !flush) | REQ. It is low in DONE, so the EX/MEM register advances at the end of DONE and the same instruction is never reissued.
- Minimum latency: 3 cycles (IDLE → REQ with same-cycle ack → DONE).
- mem_load_valid pulses in DONE for loads only, unless flush was seen at any point during the transaction (sticky flag, cleared in IDLE).
- flush does not cancel an issued bus request; the transaction completes and only the result is suppressed.
- Store lanes:
  - sb: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - sh: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - sw: wdata = rs2, wstrb = 1111.
- Load extract:
  - byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Without the optional feature, misaligned offsets use the lane selection above: sh/lh with addr[0] = 1 use addr[1] only, and sw/lw ignore addr[1:0].
- mem_load_data holds its value until the next captured load.
- Reset (rst = 0 at any edge, including mid-transaction):
  - State returns to IDLE; dmem_req, dmem_we, dmem_wstrb, mem_load_valid and mem_bus_err go to 0.
  - dmem_addr, dmem_wdata and mem_load_data go to 0; the counter and flush flag are cleared.
  - The bus transaction is abandoned without waiting for ack.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus request.
  - The FSM goes IDLE → DONE directly and adds output mem_misalign (1 bit), which pulses in DONE.
  - mem_load_valid stays 0 and stall is high for 1 cycle.
- Undefined: no port, and misaligned accesses are handled by forced lane selection as in Behaviour.

Test Plan:
- Reset with rst = 0 for 2 cycles during REQ → dmem_req = 0 and mem_stall = 0 the next cycle; a fresh access then proceeds normally.
- sw: addr 0x1000_0006 (aligned case 0x1000_0004), rs2 = 0xDEADBEEF, ack after 2 cycles → dmem_addr = 0x1000_0004, wstrb = 1111, wdata = 0xDEADBEEF, stall high 3 cycles, no load_valid.
- sb: addr 0x0000_0013, rs2 = 0x0000_00A5 → wstrb = 1000, wdata = 0xA5A5A5A5.
- lb / lbu at addr 0x0000_0022, rdata = 0x0080_0000 → load_data = 0xFFFF_FF80 / 0x0000_0080. lh at addr 0x2, rdata = 0x8001_0000 → 0xFFFF_8001.
- Load with no ack, TIMEOUT_CYCLES = 4 → mem_bus_err pulses after 4 REQ cycles, load_data = 0, load_valid = 1. Load with flush asserted during REQ and ack 1 cycle later → transaction completes, load_valid stays 0.
- With MEM_MISALIGN_TRAP_EN: lw at addr 0x0000_0001 → dmem_req never asserted, mem_misalign pulses once, stall high exactly 1 cycle.

Source files
------------

// File: rtl/me_mem_access_if.sv
// Data-memory bus between the MEM stage and the data memory.
// The MEM stage is the master: it drives the request, and the memory answers with ack/rdata.
interface me_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/me_mem_access.sv
// MEM-stage data-memory access unit.
// Converts EX/MEM load/store controls into one req/ack bus transaction and stalls
// the pipeline while it is outstanding. Load results are returned aligned and extended.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned half/word
// accesses skip the bus and pulse mem_misalign instead.

// One byte lane of the store path: picks the source byte and the strobe bit for its lane.
module me_mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,    // 0 none, 1 byte, 2 half, 3 word
  input  logic [1:0] off,     // addr[1:0]
  input  logic [7:0] b_src,   // rs2[7:0]
  input  logic [7:0] h_src,   // rs2 byte at this lane's offset inside a halfword
  input  logic [7:0] w_src,   // rs2 byte at this lane's offset inside a word
  output logic [7:0] wbyte,
  output logic       strb
);
  localparam logic [1:0] L = 2'(LANE);

  // Lane replication and byte-enable for the current store size.
  always_comb begin
    wbyte = '0;
    strb  = 1'b0;
    case (size)
      2'd1: begin wbyte = b_src; strb = (off == L);       end
      2'd2: begin wbyte = h_src; strb = (off[1] == L[1]); end
      2'd3: begin wbyte = w_src; strb = 1'b1;             end
      default: ;
    endcase
  end
endmodule

module me_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       me_write_ram_flag,
  input  logic [2:0]       me_read_ram_flag,
  input  logic [31:0]      me_alu_out,
  input  logic [31:0]      me_rs2_data,
  me_mem_access_if.master  bus,
  output logic             mem_stall,
  output logic [31:0]      mem_load_data,
  output logic             mem_load_valid,
  output logic             mem_bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             mem_misalign
`endif
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        flush_seen;
  logic [2:0]  rd_kind;     // latched load type, 0 for stores
  logic [1:0]  addr_lo;     // latched byte offset for load extraction

  logic        is_wr, is_rd, access;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata;
  logic [NUM_LANES-1:0]             lane_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode: any store wins over a load; read codes 6/7 are no-ops.
  always_comb begin
    is_wr  = (me_write_ram_flag != 2'd0);
    is_rd  = !is_wr && (me_read_ram_flag >= 3'd1) && (me_read_ram_flag <= 3'd5);
    access = is_wr || is_rd;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic [1:0] acc_size;
  logic       misaligned;

  // Access size across loads and stores, used only to detect misalignment.
  always_comb begin
    acc_size = 2'd0;
    if (is_wr) acc_size = me_write_ram_flag;
    else if (is_rd) begin
      case (me_read_ram_flag)
        3'd1, 3'd4: acc_size = 2'd1;
        3'd2, 3'd5: acc_size = 2'd2;
        default:    acc_size = 2'd3;
      endcase
    end
    misaligned = ((acc_size == 2'd2) && me_alu_out[0]) ||
                 ((acc_size == 2'd3) && (me_alu_out[1:0] != 2'd0));
  end
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    me_mem_access_lane #(.LANE(i)) u_lane (
      .size  (me_write_ram_flag),
      .off   (me_alu_out[1:0]),
      .b_src (me_rs2_data[7:0]),
      .h_src (me_rs2_data[LANE_W*(i%2) +: LANE_W]),
      .w_src (me_rs2_data[LANE_W*i +: LANE_W]),
      .wbyte (lane_wdata[i]),
      .strb  (lane_strb[i])
    );
  end

  // Load extraction from the returned word using the latched offset and type.
  always_comb begin
    ld_byte = bus.dmem_rdata[{addr_lo, 3'b000} +: 8];
    ld_half = bus.dmem_rdata[{addr_lo[1], 4'b0000} +: 16];
    case (rd_kind)
      3'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.dmem_rdata;
    endcase
  end

  // Hold earlier stages while issuing and while waiting; DONE lets EX/MEM advance.
  assign mem_stall = ((state == S_IDLE) && access && !flush) || (state == S_REQ);

  // Transaction FSM with all bus and result outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      flush_seen     <= 1'b0;
      rd_kind        <= '0;
      addr_lo        <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_wstrb <= '0;
      mem_load_data  <= '0;
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign   <= 1'b0;
`endif
    end else begin
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          cnt        <= '0;
          flush_seen <= 1'b0;
          if (access && !flush) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (misaligned) begin
              mem_misalign <= 1'b1;
              state        <= S_DONE;
            end else begin
`endif
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= is_wr;
              bus.dmem_addr  <= {me_alu_out[31:2], 2'b00};
              bus.dmem_wdata <= is_wr ? lane_wdata : '0;
              bus.dmem_wstrb <= is_wr ? lane_strb : 4'b0000;
              rd_kind        <= is_wr ? 3'd0 : me_read_ram_flag;
              addr_lo        <= me_alu_out[1:0];
              state          <= S_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
            end
`endif
          end
        end
        S_REQ: begin
          // A flush never cancels the bus cycle, it only suppresses the result.
          if (flush) flush_seen <= 1'b1;
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            state        <= S_DONE;
            if (rd_kind != 3'd0) begin
              mem_load_data  <= ld_ext;
              mem_load_valid <= !flush_seen && !flush;
            end
          end else if (cnt == CNT_LAST) begin
            bus.dmem_req <= 1'b0;
            mem_bus_err  <= 1'b1;
            state        <= S_DONE;
            if (rd_kind != 3'd0) begin
              mem_load_data  <= '0;
              mem_load_valid <= !flush_seen && !flush;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
